wb_slave_interface: RTL

- Wishbone B4 pipelined slave port of the NIC: the peer of wb_master_interface, on the local core's bus.
- Collects single or incrementing-burst write and read requests from a local bus master into a beat buffer, then streams them to the NIC output queue (packetizer) as one message.
- For reads, returns the remote reply beats to the waiting master with ACK_O.

---
 rtl/wb_slave_interface.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_slave_interface.sv
// Wishbone B4 pipelined slave for the NIC. Buffers a single or incrementing-burst request,
// hands it to the output queue as one message, and returns read replies with ACK_O.
module wb_slave_interface #(
    parameter int unsigned BUS_DATA_WIDTH      = 32,
    parameter int unsigned BUS_ADDRESS_WIDTH   = 32,
    parameter int unsigned GRANULARITY         = 8,
    parameter int unsigned MAX_BEATS           = 8,
    parameter int unsigned N_BITS_BURST_LENGHT = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  CYC_I,
    input  logic                                  STB_I,
    input  logic                                  WE_I,
    input  logic [BUS_ADDRESS_WIDTH-1:0]          ADR_I,
    input  logic [BUS_DATA_WIDTH-1:0]             DAT_I,
    input  logic [BUS_DATA_WIDTH/GRANULARITY-1:0] SEL_I,
    input  logic [2:0]                            CTI_I,
    output logic                                  ACK_O,
    output logic                                  RTY_O,
    output logic                                  ERR_O,
    output logic                                  STALL_O,
    output logic [BUS_DATA_WIDTH-1:0]             DAT_O,
    input  logic                                  queue_full_i,
    output logic                                  message_valid_o,
    output logic [BUS_ADDRESS_WIDTH-1:0]          address_o,
    output logic [BUS_DATA_WIDTH/GRANULARITY-1:0] sel_o,
    output logic                                  transaction_type_o,
    output logic [N_BITS_BURST_LENGHT-1:0]        burst_lenght_o,
    output logic [BUS_DATA_WIDTH-1:0]             data_o,
    input  logic                                  next_data_i,
    input  logic                                  message_transmitted_i,
    input  logic                                  reply_valid_i,
    input  logic [BUS_DATA_WIDTH-1:0]             reply_data_i,
    output logic                                  reply_next_o
);

    localparam int unsigned SelW = BUS_DATA_WIDTH / GRANULARITY;
    localparam int unsigned PtrW = N_BITS_BURST_LENGHT;
    localparam int unsigned CntW = N_BITS_BURST_LENGHT + 1;
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BEATS);
    localparam logic [2:0] CtiIncr = 3'b010;
    localparam logic [2:0] CtiEnd  = 3'b111;

    typedef enum logic [1:0] {StIdle, StCollect, StSend, StWaitReply} state_e;

    state_e                      state_q, state_d;
    logic [CntW-1:0]             count_q, count_d;
    logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]             reply_cnt_q, reply_cnt_d;
    logic [BUS_ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [SelW-1:0]             sel_q, sel_d;
    logic                        we_q, we_d;
    logic                        ack_q, ack_d;
    logic                        rty_q, rty_d;
    logic                        err_q, err_d;
    logic                        rsupp_q, rsupp_d;
    logic [BUS_DATA_WIDTH-1:0]   dat_o_q, dat_o_d;
    logic [BUS_DATA_WIDTH-1:0]   beat_buf_q [MAX_BEATS];

    logic                        accept;
    logic                        buf_we;
    logic [PtrW-1:0]             buf_waddr;

    assign STALL_O            = (state_q == StSend) || (state_q == StWaitReply);
    assign accept             = CYC_I && STB_I && !STALL_O;
    assign message_valid_o    = (state_q == StSend);
    assign burst_lenght_o     = (count_q == '0) ? '0 : PtrW'(count_q - CntW'(1));
    assign data_o             = beat_buf_q[rd_ptr_q];
    assign address_o          = addr_q;
    assign sel_o              = sel_q;
    assign transaction_type_o = we_q;
    assign ACK_O              = ack_q;
    assign RTY_O              = rty_q;
    assign ERR_O              = err_q;
    assign DAT_O              = dat_o_q;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        reply_cnt_d  = reply_cnt_q;
        addr_d       = addr_q;
        sel_d        = sel_q;
        we_d         = we_q;
        ack_d        = 1'b0;
        rty_d        = 1'b0;
        err_d        = 1'b0;
        rsupp_d      = rsupp_q;
        dat_o_d      = dat_o_q;
        buf_we       = 1'b0;
        buf_waddr    = '0;
        reply_next_o = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (queue_full_i) begin
                        rty_d = 1'b1;
                    end else begin
                        addr_d   = ADR_I;
                        sel_d    = SEL_I;
                        we_d     = WE_I;
                        count_d  = CntW'(1);
                        rd_ptr_d = '0;
                        buf_we   = WE_I;
                        ack_d    = WE_I;
                        state_d  = (CTI_I == CtiIncr) ? StCollect : StSend;
                    end
                end
            end
            StCollect: begin
                if (!CYC_I) begin
                    count_d = '0;
                    state_d = StIdle;
                end else if (accept) begin
                    // A beat beyond MAX_BEATS would overrun the buffer: drop the whole message.
                    if (count_q == MaxCnt) begin
                        err_d   = 1'b1;
                        count_d = '0;
                        state_d = StIdle;
                    end else begin
                        buf_we    = we_q;
                        buf_waddr = count_q[PtrW-1:0];
                        count_d   = count_q + CntW'(1);
                        ack_d     = we_q;
                        if (CTI_I == CtiEnd) begin
                            state_d = StSend;
                        end
                    end
                end
            end
            StSend: begin
                if (message_transmitted_i) begin
                    rd_ptr_d    = '0;
                    reply_cnt_d = '0;
                    rsupp_d     = 1'b0;
                    state_d     = we_q ? StIdle : StWaitReply;
                end else if (next_data_i && (({1'b0, rd_ptr_q} + CntW'(1)) < count_q)) begin
                    rd_ptr_d = rd_ptr_q + PtrW'(1);
                end
            end
            StWaitReply: begin
                // Once the master abandons the cycle, the remaining replies are drained silently.
                if (!CYC_I) begin
                    rsupp_d = 1'b1;
                end
                if (reply_valid_i) begin
                    reply_next_o = 1'b1;
                    reply_cnt_d  = reply_cnt_q + PtrW'(1);
                    if (CYC_I && !rsupp_q) begin
                        ack_d   = 1'b1;
                        dat_o_d = reply_data_i;
                    end
                    if (reply_cnt_q == burst_lenght_o) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            reply_cnt_q <= '0;
            addr_q      <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            ack_q       <= 1'b0;
            rty_q       <= 1'b0;
            err_q       <= 1'b0;
            rsupp_q     <= 1'b0;
            dat_o_q     <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            reply_cnt_q <= reply_cnt_d;
            addr_q      <= addr_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            ack_q       <= ack_d;
            rty_q       <= rty_d;
            err_q       <= err_d;
            rsupp_q     <= rsupp_d;
            dat_o_q     <= dat_o_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(MAX_BEATS); i++) begin
                beat_buf_q[i] <= '0;
            end
        end else if (buf_we) begin
            beat_buf_q[buf_waddr] <= DAT_I;
        end
    end

endmodule
